indirect_target_predictor: RTL and testbench
============================================

INDIRECT_TARGET_PREDICTOR -- requirements
Module: indirect_target_predictor

Interface
REQ-001 SHALL have parameter NUM_UPDATES, default 2: number of update slots per cycle.
REQ-002 SHALL have parameter NUM_ENTRIES, default 16: table entries, power of two, at least 2; IDX = log2(NUM_ENTRIES).
REQ-003 SHALL have parameter TAG_BITS, default 8: stored tag width; IDX+TAG_BITS <= 31.
REQ-004 SHALL have port clk  input  1  clock, all state on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port IN_clearICache  input  1  flush of all predictor state.
REQ-007 SHALL have port IN_lookupValid  input  1  lookup request this cycle.
REQ-008 SHALL have port IN_lookupPC  input  31  branch PC to predict.
REQ-009 SHALL have port IN_ibUpdates  input  NUM_UPDATES*63  per slot i, base b=i*63: [b] valid, [b+31:b+1] resolved dst, [b+62:b+32] branch src PC.
REQ-010 SHALL have port OUT_predValid  output  1  registered: confident table hit.
REQ-011 SHALL have port OUT_predDst  output  31  registered predicted target.

Function
REQ-012 SHALL hold NUM_ENTRIES entries, each with valid, tag[TAG_BITS], dst[31] and conf[2].
REQ-013 SHALL use index = PC[IDX-1:0] and tag = PC[IDX+TAG_BITS-1:IDX] for both lookup and update.
REQ-014 SHALL define hit as entry valid and stored tag equal to the PC tag.
REQ-015 SHALL register the lookup result one cycle after IN_lookupValid, i.e. latency 1.
REQ-016 On a lookup hit with conf >= 1, SHALL set OUT_predValid=1 and OUT_predDst=entry dst.
REQ-017 On a lookup miss or conf==0, SHALL set OUT_predValid=0 and OUT_predDst=lastDst, the dst of the most recent valid update.
REQ-018 With IN_lookupValid=0, SHALL set OUT_predValid=0 and hold OUT_predDst.
REQ-019 A lookup SHALL observe table state before any same-cycle update (read-before-write).
REQ-020 Update, hit and dst equal: SHALL increment conf, saturating at 3.
REQ-021 Update, hit and dst different: if conf==0, SHALL write dst and set conf=1; otherwise SHALL decrement conf and keep dst.
REQ-022 Update, miss: if the entry is invalid or conf==0, SHALL allocate (valid=1, new tag, dst, conf=1); otherwise SHALL decrement conf.
REQ-023 Multiple valid slots in one cycle SHALL be applied in ascending slot order, each seeing the result of lower slots, including slots hitting the same index.
REQ-024 lastDst SHALL take the dst of the highest-numbered valid slot each cycle, and hold when no slot is valid.
REQ-025 IN_clearICache SHALL clear all valid bits and conf fields, zero lastDst and zero both outputs next cycle.
REQ-026 IN_clearICache SHALL take priority over same-cycle updates and lookups, which are discarded.
REQ-027 Slots with valid=0 SHALL have no effect regardless of payload.

Reset
REQ-028 rst SHALL produce the same state as IN_clearICache and override all other inputs.
REQ-029 After rst: OUT_predValid=0, OUT_predDst=0, all entries invalid, lastDst=0.
REQ-030 Reset mid-operation SHALL abort pending effects; the first post-reset lookup SHALL miss.

Verification
REQ-031 Cold miss: after rst, lookup PC 0x100 -> next cycle predValid=0, predDst=0.
REQ-032 Train and predict: update src 0x100, dst 0x4000, then lookup 0x100 -> predValid=1, predDst=0x4000; two more equal updates give conf=3.
REQ-033 Hysteresis: conf=3 entry dst 0x4000; updates dst 0x5000 x3 leave dst 0x4000 (conf 0); 4th update -> lookup returns 0x5000, predValid=1.
REQ-034 Same-cycle ordering: slot0 and slot1 both src 0x200 (miss, empty), dst 0x10 and 0x20 -> entry dst 0x10, conf=0, entry valid; lookup gives predValid=0, predDst=lastDst=0x20.
REQ-035 Alias: src 0x100 trained conf=3; update src 0x100+(NUM_ENTRIES<<0)*... with same index, different tag -> conf drops to 2, no replacement; lookup of the alias PC misses.
REQ-036 Flush priority: IN_clearICache with a valid update and lookup in the same cycle -> next cycle predValid=0, predDst=0; prior trained PC then misses.

Source files
------------

// File: rtl/indirect_target_predictor.sv
// rtl/indirect_target_predictor.sv - direct-mapped indirect branch target predictor with 2-bit hysteresis
module indirect_target_predictor #(
    parameter int NUM_UPDATES = 2,
    parameter int NUM_ENTRIES = 16,
    parameter int TAG_BITS    = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      IN_clearICache,
    input  logic                      IN_lookupValid,
    input  logic [30:0]               IN_lookupPC,
    input  logic [NUM_UPDATES*63-1:0] IN_ibUpdates,
    output logic                      OUT_predValid,
    output logic [30:0]               OUT_predDst
);

    localparam int IDX = $clog2(NUM_ENTRIES);

    logic [NUM_ENTRIES-1:0] valid_q, valid_n;
    logic [TAG_BITS-1:0]    tag_q  [NUM_ENTRIES];
    logic [TAG_BITS-1:0]    tag_n  [NUM_ENTRIES];
    logic [30:0]            dst_q  [NUM_ENTRIES];
    logic [30:0]            dst_n  [NUM_ENTRIES];
    logic [1:0]             conf_q [NUM_ENTRIES];
    logic [1:0]             conf_n [NUM_ENTRIES];
    logic [30:0]            last_dst_q, last_dst_n;

    logic [IDX-1:0]      lookup_idx;
    logic [TAG_BITS-1:0] lookup_tag;
    logic                lookup_hit;
    logic                lookup_conf;

    assign lookup_idx  = IN_lookupPC[IDX-1:0];
    assign lookup_tag  = IN_lookupPC[IDX+TAG_BITS-1:IDX];
    assign lookup_hit  = valid_q[lookup_idx] && (tag_q[lookup_idx] == lookup_tag);
    assign lookup_conf = lookup_hit && (conf_q[lookup_idx] != 2'd0);

    generate
        if (IDX + TAG_BITS < 31) begin : g_unused_pc
            logic unused_pc_bits;
            assign unused_pc_bits = ^IN_lookupPC[30:IDX+TAG_BITS];
        end
    endgenerate

    // Slots are folded into a working copy of the table in ascending order so
    // later slots observe earlier ones, even when they share an index.
    always_comb begin
        valid_n    = valid_q;
        tag_n      = tag_q;
        dst_n      = dst_q;
        conf_n     = conf_q;
        last_dst_n = last_dst_q;
        for (int s = 0; s < NUM_UPDATES; s++) begin
            logic                u_valid;
            logic [30:0]         u_dst;
            logic [30:0]         u_src;
            logic [IDX-1:0]      u_idx;
            logic [TAG_BITS-1:0] u_tag;
            logic                u_hit;
            u_valid = IN_ibUpdates[s*63];
            u_dst   = IN_ibUpdates[s*63+1 +: 31];
            u_src   = IN_ibUpdates[s*63+32 +: 31];
            u_idx   = u_src[IDX-1:0];
            u_tag   = u_src[IDX+TAG_BITS-1:IDX];
            u_hit   = valid_n[u_idx] && (tag_n[u_idx] == u_tag);
            if (u_valid) begin
                last_dst_n = u_dst;
                if (u_hit && (dst_n[u_idx] == u_dst)) begin
                    if (conf_n[u_idx] != 2'd3)
                        conf_n[u_idx] = conf_n[u_idx] + 2'd1;
                end else if (u_hit) begin
                    if (conf_n[u_idx] == 2'd0) begin
                        dst_n[u_idx]  = u_dst;
                        conf_n[u_idx] = 2'd1;
                    end else begin
                        conf_n[u_idx] = conf_n[u_idx] - 2'd1;
                    end
                end else if (!valid_n[u_idx] || (conf_n[u_idx] == 2'd0)) begin
                    valid_n[u_idx] = 1'b1;
                    tag_n[u_idx]   = u_tag;
                    dst_n[u_idx]   = u_dst;
                    conf_n[u_idx]  = 2'd1;
                end else begin
                    conf_n[u_idx] = conf_n[u_idx] - 2'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || IN_clearICache) begin
            valid_q       <= '0;
            last_dst_q    <= '0;
            OUT_predValid <= 1'b0;
            OUT_predDst   <= '0;
            for (int e = 0; e < NUM_ENTRIES; e++)
                conf_q[e] <= 2'd0;
        end else begin
            valid_q    <= valid_n;
            last_dst_q <= last_dst_n;
            for (int e = 0; e < NUM_ENTRIES; e++) begin
                tag_q[e]  <= tag_n[e];
                dst_q[e]  <= dst_n[e];
                conf_q[e] <= conf_n[e];
            end
            // Lookup reads the pre-update table and the pre-update lastDst.
            if (IN_lookupValid) begin
                OUT_predValid <= lookup_conf;
                OUT_predDst   <= lookup_conf ? dst_q[lookup_idx] : last_dst_q;
            end else begin
                OUT_predValid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_indirect_target_predictor.sv
// tb/tb_indirect_target_predictor.sv - directed vector bench for indirect_target_predictor
module tb_indirect_target_predictor;

    logic         clk = 1'b0;
    logic         rst;
    logic         clr;
    logic         lv;
    logic [30:0]  lpc;
    logic [125:0] ib;
    logic         pred_valid;
    logic [30:0]  pred_dst;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    indirect_target_predictor #(.NUM_UPDATES(2), .NUM_ENTRIES(16), .TAG_BITS(8)) dut (
        .clk            (clk),
        .rst            (rst),
        .IN_clearICache (clr),
        .IN_lookupValid (lv),
        .IN_lookupPC    (lpc),
        .IN_ibUpdates   (ib),
        .OUT_predValid  (pred_valid),
        .OUT_predDst    (pred_dst)
    );

    typedef struct {
        logic        rst;
        logic        clr;
        logic        lv;
        logic [30:0] lpc;
        logic        u0v;
        logic [30:0] u0s;
        logic [30:0] u0d;
        logic        u1v;
        logic [30:0] u1s;
        logic [30:0] u1d;
        logic        ev;
        logic [30:0] ed;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic r, logic c, logic l, logic [30:0] pc,
                                logic a_v, logic [30:0] a_s, logic [30:0] a_d,
                                logic b_v, logic [30:0] b_s, logic [30:0] b_d,
                                logic e_v, logic [30:0] e_d);
        vec_t v;
        v.rst = r;   v.clr = c;   v.lv = l;    v.lpc = pc;
        v.u0v = a_v; v.u0s = a_s; v.u0d = a_d;
        v.u1v = b_v; v.u1s = b_s; v.u1d = b_d;
        v.ev  = e_v; v.ed  = e_d;
        return v;
    endfunction

    task automatic check(string name, logic ev, logic [30:0] ed);
        tests++;
        if (pred_valid !== ev) begin
            fails++;
            $display("FAIL %s predValid got %0b want %0b", name, pred_valid, ev);
        end
        tests++;
        if (pred_dst !== ed) begin
            fails++;
            $display("FAIL %s predDst got %h want %h", name, pred_dst, ed);
        end
    endtask

    task automatic apply(vec_t v, string name);
        rst = v.rst;
        clr = v.clr;
        lv  = v.lv;
        lpc = v.lpc;
        ib  = {v.u1s, v.u1d, v.u1v, v.u0s, v.u0d, v.u0v};
        @(posedge clk);
        #1;
        check(name, v.ev, v.ed);
    endtask

    initial begin
        rst = 1'b1; clr = 1'b0; lv = 1'b0; lpc = '0; ib = '0;

        //             rst  clr  lv   pc            u0v  src           dst           u1v  src    dst      ev   ed
        vecs.push_back(mk(1, 0, 0, 31'h0,        0, 31'h0,        31'h0,        0, 31'h0,   31'h0,    0, 31'h0));
        vecs.push_back(mk(0, 0, 1, 31'h100,      0, 31'h0,        31'h0,        0, 31'h0,   31'h0,    0, 31'h0));
        vecs.push_back(mk(0, 0, 0, 31'h0,        1, 31'h100,      31'h4000,     0, 31'h0,   31'h0,    0, 31'h0));
        vecs.push_back(mk(0, 0, 1, 31'h100,      0, 31'h0,        31'h0,        0, 31'h0,   31'h0,    1, 31'h4000));
        vecs.push_back(mk(0, 0, 0, 31'h0,        1, 31'h100,      31'h4000,     1, 31'h100, 31'h4000, 0, 31'h4000));
        vecs.push_back(mk(0, 0, 1, 31'h100,      1, 31'h100,      31'h5000,     0, 31'h0,   31'h0,    1, 31'h4000));
        vecs.push_back(mk(0, 0, 0, 31'h0,        1, 31'h100,      31'h5000,     1, 31'h100, 31'h5000, 0, 31'h4000));
        vecs.push_back(mk(0, 0, 1, 31'h100,      0, 31'h0,        31'h0,        0, 31'h0,   31'h0,    0, 31'h5000));
        vecs.push_back(mk(0, 0, 0, 31'h0,        0, 31'h100,      31'h7777,     1, 31'h100, 31'h5000, 0, 31'h5000));
        vecs.push_back(mk(0, 0, 1, 31'h100,      0, 31'h0,        31'h0,        0, 31'h0,   31'h0,    1, 31'h5000));
        vecs.push_back(mk(1, 0, 1, 31'h100,      1, 31'h100,      31'h5000,     0, 31'h0,   31'h0,    0, 31'h0));
        vecs.push_back(mk(0, 0, 1, 31'h100,      0, 31'h0,        31'h0,        0, 31'h0,   31'h0,    0, 31'h0));
        vecs.push_back(mk(0, 0, 0, 31'h0,        1, 31'h200,      31'h10,       1, 31'h200, 31'h20,   0, 31'h0));
        vecs.push_back(mk(0, 0, 1, 31'h200,      0, 31'h0,        31'h0,        0, 31'h0,   31'h0,    0, 31'h20));
        vecs.push_back(mk(0, 0, 0, 31'h0,        0, 31'h0,        31'h0,        1, 31'h200, 31'h10,   0, 31'h20));
        vecs.push_back(mk(0, 0, 1, 31'h200,      0, 31'h0,        31'h0,        0, 31'h0,   31'h0,    1, 31'h10));
        vecs.push_back(mk(1, 0, 0, 31'h0,        0, 31'h0,        31'h0,        0, 31'h0,   31'h0,    0, 31'h0));
        vecs.push_back(mk(0, 0, 0, 31'h0,        1, 31'h100,      31'h4000,     1, 31'h100, 31'h4000, 0, 31'h0));
        vecs.push_back(mk(0, 0, 0, 31'h0,        1, 31'h100,      31'h4000,     0, 31'h0,   31'h0,    0, 31'h0));
        vecs.push_back(mk(0, 0, 0, 31'h0,        1, 31'h110,      31'h9000,     0, 31'h0,   31'h0,    0, 31'h0));
        vecs.push_back(mk(0, 0, 1, 31'h110,      0, 31'h0,        31'h0,        0, 31'h0,   31'h0,    0, 31'h9000));
        vecs.push_back(mk(0, 0, 1, 31'h100,      0, 31'h0,        31'h0,        0, 31'h0,   31'h0,    1, 31'h4000));
        vecs.push_back(mk(0, 0, 0, 31'h0,        1, 31'h110,      31'h9000,     1, 31'h110, 31'h9000, 0, 31'h4000));
        vecs.push_back(mk(0, 0, 1, 31'h100,      0, 31'h0,        31'h0,        0, 31'h0,   31'h0,    0, 31'h9000));
        vecs.push_back(mk(0, 0, 0, 31'h0,        1, 31'h110,      31'h9000,     0, 31'h0,   31'h0,    0, 31'h9000));
        vecs.push_back(mk(0, 0, 1, 31'h110,      0, 31'h0,        31'h0,        0, 31'h0,   31'h0,    1, 31'h9000));
        vecs.push_back(mk(0, 1, 1, 31'h110,      1, 31'h110,      31'hAAAA,     0, 31'h0,   31'h0,    0, 31'h0));
        vecs.push_back(mk(0, 0, 1, 31'h110,      0, 31'h0,        31'h0,        0, 31'h0,   31'h0,    0, 31'h0));
        vecs.push_back(mk(0, 0, 1, 31'h100,      0, 31'h0,        31'h0,        0, 31'h0,   31'h0,    0, 31'h0));
        vecs.push_back(mk(0, 0, 0, 31'h0,        1, 31'h7FFFFFFF, 31'h7FFFFFFE, 0, 31'h0,   31'h0,    0, 31'h0));
        vecs.push_back(mk(0, 0, 1, 31'h7FFFFFFF, 0, 31'h0,        31'h0,        0, 31'h0,   31'h0,    1, 31'h7FFFFFFE));
        vecs.push_back(mk(0, 0, 1, 31'h7FFFFFEF, 0, 31'h0,        31'h0,        0, 31'h0,   31'h0,    0, 31'h7FFFFFFE));

        for (int i = 0; i < vecs.size(); i++)
            apply(vecs[i], $sformatf("vec%0d", i));

        // Flush without a lookup must still zero the held target.
        apply(mk(0, 1, 0, 31'h0, 0, 31'h0, 31'h0, 0, 31'h0, 31'h0, 0, 31'h0), "flush_hold");
        apply(mk(0, 0, 1, 31'h7FFFFFFF, 0, 31'h0, 31'h0, 0, 31'h0, 31'h0, 0, 31'h0), "flush_miss");

        // Retrain, then hold reset for several cycles with traffic pending.
        apply(mk(0, 0, 0, 31'h0, 1, 31'h305, 31'h1234, 0, 31'h0, 31'h0, 0, 31'h0), "train305");
        apply(mk(0, 0, 1, 31'h305, 0, 31'h0, 31'h0, 0, 31'h0, 31'h0, 1, 31'h1234), "hit305");
        for (int k = 0; k < 3; k++)
            apply(mk(1, 0, 1, 31'h305, 1, 31'h305, 31'h1234, 1, 31'h305, 31'h1234, 0, 31'h0),
                  $sformatf("rst_hold%0d", k));
        apply(mk(0, 0, 1, 31'h305, 0, 31'h0, 31'h0, 0, 31'h0, 31'h0, 0, 31'h0), "post_rst_miss");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
